// File: rtl/mi_rr_arbiter.sv
// mi_rr_arbiter
//   Round-robin arbiter that lets PORTS independent MI masters share one MI
//   slave port. One request at a time is held on the shared port until the
//   slave accepts it. The owner of every accepted read goes into an in-order
//   tag FIFO, and read responses are steered back to that owner.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no grant; OUT_* driven to zero
//   ST_GRANTED | port grant_idx drives OUT_* and receives OUT_ARDY
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   IN_ADDR/DWR/BE      per-port request fields, port i in slice i
//   IN_WR, IN_RD        per-port write/read requests
//   IN_ARDY             per-port accept (only the granted port sees OUT_ARDY)
//   IN_DRD, IN_DRDY     read data (OUT_DRD broadcast) and per-port data valid
//   OUT_ADDR/DWR/BE     shared request toward the slave
//   OUT_WR, OUT_RD      shared request strobes
//   OUT_ARDY            slave accept
//   OUT_DRD, OUT_DRDY   slave read data and data valid
//   ERR_UNEXP_DRDY      sticky: read data arrived with no read outstanding
module mi_rr_arbiter #(
  parameter int PORTS          = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RD_OUTSTANDING = 8
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [PORTS*ADDR_WIDTH-1:0]    IN_ADDR,
  input  logic [PORTS*DATA_WIDTH-1:0]    IN_DWR,
  input  logic [PORTS*DATA_WIDTH/8-1:0]  IN_BE,
  input  logic [PORTS-1:0]               IN_WR,
  input  logic [PORTS-1:0]               IN_RD,
  output logic [PORTS-1:0]               IN_ARDY,
  output logic [PORTS*DATA_WIDTH-1:0]    IN_DRD,
  output logic [PORTS-1:0]               IN_DRDY,
  output logic [ADDR_WIDTH-1:0]          OUT_ADDR,
  output logic [DATA_WIDTH-1:0]          OUT_DWR,
  output logic [DATA_WIDTH/8-1:0]        OUT_BE,
  output logic                           OUT_WR,
  output logic                           OUT_RD,
  input  logic                           OUT_ARDY,
  input  logic [DATA_WIDTH-1:0]          OUT_DRD,
  input  logic                           OUT_DRDY,
  output logic                           ERR_UNEXP_DRDY
);

  localparam int BEW  = DATA_WIDTH / 8;
  localparam int IDXW = $clog2(PORTS);
  localparam int PTRW = $clog2(RD_OUTSTANDING);
  localparam int CNTW = PTRW + 1;

  typedef enum logic {ST_IDLE, ST_GRANTED} state_t;

  state_t            state, state_n;
  logic [IDXW-1:0]   grant_idx, grant_idx_n;
  logic [IDXW-1:0]   rr_ptr, rr_ptr_n;
  logic [IDXW-1:0]   rr_inc;
  logic              grant_vld;

  logic [IDXW-1:0]   tag_mem [RD_OUTSTANDING];
  logic [PTRW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0]   rd_count;
  logic [IDXW-1:0]   head_tag;
  logic              err_unexp;

  logic [ADDR_WIDTH-1:0] addr_arr [PORTS];
  logic [DATA_WIDTH-1:0] dwr_arr  [PORTS];
  logic [BEW-1:0]        be_arr   [PORTS];

  logic              gnt_wr, gnt_rd;
  logic              accept, push, pop;
  logic              full, sel_full;
  logic [PORTS-1:0]  elig, gnt_onehot;
  logic [IDXW:0]     pick_idle, pick_rearb;
  logic [PORTS-1:0]  ardy_vec, drdy_vec;

  // First set bit of req scanning upward from start with wrap-around.
  // Returns {found, index}.
  function automatic logic [IDXW:0] rr_pick(input logic [PORTS-1:0] req,
                                            input logic [IDXW-1:0]  start);
    logic            found;
    logic [IDXW-1:0] win;
    logic [IDXW-1:0] idx;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = IDXW'((int'(start) + k) % PORTS);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  for (genvar g = 0; g < PORTS; g++) begin : g_slice
    assign addr_arr[g] = IN_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign dwr_arr[g]  = IN_DWR[g*DATA_WIDTH +: DATA_WIDTH];
    assign be_arr[g]   = IN_BE[g*BEW +: BEW];
  end

  assign grant_vld = (state == ST_GRANTED);
  assign gnt_wr    = IN_WR[grant_idx];
  assign gnt_rd    = IN_RD[grant_idx];

  assign OUT_WR   = grant_vld & gnt_wr;
  assign OUT_RD   = grant_vld & gnt_rd;
  assign OUT_ADDR = grant_vld ? addr_arr[grant_idx] : '0;
  assign OUT_DWR  = grant_vld ? dwr_arr[grant_idx]  : '0;
  assign OUT_BE   = grant_vld ? be_arr[grant_idx]   : '0;

  assign accept = (OUT_RD | OUT_WR) & OUT_ARDY;
  // RD together with WR counts as a read for the tag FIFO.
  assign push   = accept & OUT_RD;
  assign pop    = OUT_DRDY & (rd_count != '0);

  assign full = (rd_count == CNTW'(RD_OUTSTANDING));
  // The re-selection that follows a read accept must also see the slot that
  // read is taking, otherwise a second read could be granted into a FIFO
  // that is already full. A same-cycle pop is deliberately ignored.
  assign sel_full = full | (push & (rd_count == CNTW'(RD_OUTSTANDING - 1)));

  assign elig = IN_WR | (IN_RD & {PORTS{~sel_full}});

  always_comb begin
    gnt_onehot            = '0;
    gnt_onehot[grant_idx] = 1'b1;
  end

  assign rr_inc     = (grant_idx == IDXW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
  assign pick_idle  = rr_pick(elig, rr_ptr);
  assign pick_rearb = rr_pick(elig & ~gnt_onehot, rr_inc);

  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    rr_ptr_n    = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (pick_idle[IDXW]) begin
          state_n     = ST_GRANTED;
          grant_idx_n = pick_idle[IDXW-1:0];
        end
      end
      ST_GRANTED: begin
        if (accept) begin
          rr_ptr_n = rr_inc;
          if (pick_rearb[IDXW]) begin
            grant_idx_n = pick_rearb[IDXW-1:0];
          end else begin
            state_n = ST_IDLE;
          end
        end else if (!(gnt_wr | gnt_rd)) begin
          // Master withdrew its request; fairness pointer is left alone.
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      rr_ptr    <= rr_ptr_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_count  <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   rd_count <= rd_count + 1'b1;
        2'b01:   rd_count <= rd_count - 1'b1;
        default: rd_count <= rd_count;
      endcase
      if (OUT_DRDY && (rd_count == '0)) err_unexp <= 1'b1;
    end
  end

  assign head_tag = tag_mem[rd_ptr];

  always_comb begin
    ardy_vec = '0;
    if (grant_vld) ardy_vec[grant_idx] = OUT_ARDY;
  end

  always_comb begin
    drdy_vec = '0;
    if (pop) drdy_vec[head_tag] = 1'b1;
  end

  assign IN_ARDY        = ardy_vec;
  assign IN_DRDY        = drdy_vec;
  assign IN_DRD         = {PORTS{OUT_DRD}};
  assign ERR_UNEXP_DRDY = err_unexp;

endmodule

// File: tb/tb_mi_rr_arbiter.sv
// Directed bench for mi_rr_arbiter: one linear stimulus sequence; expected
// accepts and read responses are queued when stimulus is driven and checked
// when the arbiter produces them.
module tb_mi_rr_arbiter;
  localparam int P   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int RDO = 8;

  typedef logic [1:0] port_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [P*AW-1:0]  in_addr;
  logic [P*DW-1:0]  in_dwr;
  logic [P*DW/8-1:0] in_be;
  logic [P-1:0]     in_wr, in_rd, in_ardy, in_drdy;
  logic [P*DW-1:0]  in_drd;
  logic [AW-1:0]    out_addr;
  logic [DW-1:0]    out_dwr;
  logic [DW/8-1:0]  out_be;
  logic             out_wr, out_rd, out_ardy, out_drdy, err;
  logic [DW-1:0]    out_drd;

  logic [AW-1:0]    addr_a [P];
  logic [DW-1:0]    dwr_a  [P];
  logic [DW-1:0]    drd_a  [P];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit slave_auto = 1'b0;

  port_t       exp_acc[$];
  port_t       exp_rd_port[$];
  int          rsp_due[$];
  logic [31:0] rsp_data[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < P; g++) begin : g_pack
    assign in_addr[g*AW +: AW]  = addr_a[g];
    assign in_dwr[g*DW +: DW]   = dwr_a[g];
    assign in_be[g*4 +: 4]      = 4'hF;
    assign drd_a[g]             = in_drd[g*DW +: DW];
  end

  mi_rr_arbiter #(
    .PORTS(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_OUTSTANDING(RDO)
  ) dut (
    .CLK(clk), .RESET(reset),
    .IN_ADDR(in_addr), .IN_DWR(in_dwr), .IN_BE(in_be),
    .IN_WR(in_wr), .IN_RD(in_rd), .IN_ARDY(in_ardy),
    .IN_DRD(in_drd), .IN_DRDY(in_drdy),
    .OUT_ADDR(out_addr), .OUT_DWR(out_dwr), .OUT_BE(out_be),
    .OUT_WR(out_wr), .OUT_RD(out_rd), .OUT_ARDY(out_ardy),
    .OUT_DRD(out_drd), .OUT_DRDY(out_drdy),
    .ERR_UNEXP_DRDY(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input port_t p, input logic wr, input logic rd,
                          input logic [31:0] addr, input logic [31:0] dwr);
    in_wr[p]  = wr;
    in_rd[p]  = rd;
    addr_a[p] = addr;
    dwr_a[p]  = dwr;
  endtask

  // Runs just before the active edge, once inputs of this cycle are final.
  task automatic monitor();
    port_t       p;
    logic [P-1:0] oh;
    if (out_drdy === 1'b1) begin
      if (exp_rd_port.size() > 0) begin
        p = exp_rd_port.pop_front();
        oh = '0;
        oh[p] = 1'b1;
        chk("drdy_port", 64'(in_drdy), 64'(oh));
        chk("drd_data", 64'(drd_a[p]), 64'(out_drd));
      end else begin
        chk("drdy_stray", 64'(in_drdy), 64'(0));
      end
    end else begin
      chk("drdy_idle", 64'(in_drdy), 64'(0));
    end
    if (((out_rd | out_wr) & out_ardy) === 1'b1) begin
      if (exp_acc.size() == 0) begin
        chk("unexpected_accept", 64'(in_ardy), 64'(0));
      end else begin
        p = exp_acc.pop_front();
        oh = '0;
        oh[p] = 1'b1;
        chk("accept_port", 64'(in_ardy), 64'(oh));
        chk("accept_addr", 64'(out_addr), 64'(addr_a[p]));
        if (out_rd === 1'b1) begin
          exp_rd_port.push_back(p);
          if (slave_auto) begin
            rsp_due.push_back(cyc + 3);
            rsp_data.push_back(32'hD000_0000 + 32'(cyc));
          end
        end
      end
    end
  endtask

  task automatic step();
    #1;
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (slave_auto) begin
      if (rsp_due.size() > 0 && rsp_due[0] == cyc) begin
        out_drdy = 1'b1;
        out_drd  = rsp_data.pop_front();
        void'(rsp_due.pop_front());
      end else begin
        out_drdy = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    cyc += 2;
    #2;
    reset = 1'b0;
    exp_rd_port.delete();
    rsp_due.delete();
    rsp_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_wr    = '0;
    in_rd    = '0;
    out_ardy = 1'b0;
    out_drdy = 1'b0;
    out_drd  = '0;
    addr_a   = '{default: '0};
    dwr_a    = '{default: '0};

    // Reset values
    do_reset();
    chk("rst_in_ardy", 64'(in_ardy), 64'(0));
    chk("rst_in_drdy", 64'(in_drdy), 64'(0));
    chk("rst_out_wr",  64'(out_wr), 64'(0));
    chk("rst_out_rd",  64'(out_rd), 64'(0));
    chk("rst_out_addr", 64'(out_addr), 64'(0));
    chk("rst_err",     64'(err), 64'(0));
    chk("rst_count",   64'(dut.rd_count), 64'(0));
    chk("rst_rr_ptr",  64'(dut.rr_ptr), 64'(0));

    // Single write from port 2
    out_ardy = 1'b1;
    set_port(2, 1'b1, 1'b0, 32'h10, 32'hCAFE);
    exp_acc.push_back(2);
    #1;
    chk("wr_cycle_n_idle", 64'(out_wr), 64'(0));
    step();
    chk("wr_out_wr",   64'(out_wr), 64'(1));
    chk("wr_out_addr", 64'(out_addr), 64'(32'h10));
    chk("wr_out_dwr",  64'(out_dwr), 64'(32'hCAFE));
    chk("wr_out_be",   64'(out_be), 64'(4'hF));
    chk("wr_in_ardy",  64'(in_ardy), 64'(4'b0100));
    step();
    chk("wr_ardy_one_cycle", 64'(in_ardy), 64'(0));
    chk("wr_rr_ptr", 64'(dut.rr_ptr), 64'(3));
    set_port(2, 1'b0, 1'b0, 32'h0, 32'h0);

    // Withdrawal leaves rr_ptr alone
    out_ardy = 1'b0;
    set_port(1, 1'b1, 1'b0, 32'h1000_0004, 32'h1);
    step();
    chk("wd_out_addr", 64'(out_addr), 64'(32'h1000_0004));
    chk("wd_in_ardy",  64'(in_ardy), 64'(0));
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("wd_out_wr", 64'(out_wr), 64'(0));
    chk("wd_rr_ptr", 64'(dut.rr_ptr), 64'(3));

    // Fairness: all ports read continuously, responses 3 cycles after accept
    do_reset();
    slave_auto = 1'b1;
    out_ardy   = 1'b1;
    for (int i = 0; i < P; i++)
      set_port(port_t'(i), 1'b0, 1'b1, 32'h2000_0000 + 32'(i * 16), 32'h0);
    for (int k = 0; k < 8; k++) exp_acc.push_back(port_t'(k % P));
    for (int n = 0; n < 40 && exp_acc.size() > 0; n++) step();
    chk("fair_all_accepted", 64'(exp_acc.size()), 64'(0));
    in_rd = '0;
    for (int n = 0; n < 20 && exp_rd_port.size() > 0; n++) step();
    chk("fair_all_responded", 64'(exp_rd_port.size()), 64'(0));
    chk("fair_count", 64'(dut.rd_count), 64'(0));
    slave_auto = 1'b0;
    out_drdy   = 1'b0;

    // Backpressure: port 1 granted and held, port 0 waiting
    out_ardy = 1'b0;
    set_port(1, 1'b1, 1'b0, 32'h3000_0010, 32'h11);
    step();
    set_port(0, 1'b1, 1'b0, 32'h3000_0000, 32'h22);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_hold_addr", 64'(out_addr), 64'(32'h3000_0010));
      chk("bp_hold_ardy", 64'(in_ardy), 64'(0));
    end
    out_ardy = 1'b1;
    exp_acc.push_back(1);
    exp_acc.push_back(0);
    step();
    chk("bp_next_addr", 64'(out_addr), 64'(32'h3000_0000));
    chk("bp_next_ardy", 64'(in_ardy), 64'(4'b0001));
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("bp_done", 64'(exp_acc.size()), 64'(0));

    // FIFO full: 8 reads with no response, then a write still gets through
    set_port(0, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
    set_port(1, 1'b0, 1'b1, 32'h4000_0100, 32'h0);
    for (int k = 0; k < 8; k++) exp_acc.push_back(port_t'((k % 2 == 0) ? 1 : 0));
    for (int n = 0; n < 30 && exp_acc.size() > 0; n++) step();
    chk("ff_accepted", 64'(exp_acc.size()), 64'(0));
    chk("ff_count_full", 64'(dut.rd_count), 64'(RDO));
    set_port(3, 1'b1, 1'b0, 32'h4000_0300, 32'h33);
    exp_acc.push_back(3);
    step();
    chk("ff_wr_granted", 64'(out_wr), 64'(1));
    chk("ff_rd_blocked", 64'(out_rd), 64'(0));
    step();
    chk("ff_wr_done", 64'(exp_acc.size()), 64'(0));
    set_port(3, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("ff_still_blocked", 64'(out_rd), 64'(0));
    out_drdy = 1'b1;
    out_drd  = 32'hA5A5_0001;
    step();
    out_drdy = 1'b0;
    chk("ff_pop_no_unblock", 64'(out_rd), 64'(0));
    exp_acc.push_back(0);
    step();
    chk("ff_regrant_rd", 64'(out_rd), 64'(1));
    chk("ff_regrant_addr", 64'(out_addr), 64'(32'h4000_0000));
    step();
    in_rd = '0;
    step();
    chk("ff_regrant_done", 64'(exp_acc.size()), 64'(0));
    chk("ff_count_refull", 64'(dut.rd_count), 64'(RDO));

    // Drain five responses, leaving three outstanding
    for (int k = 0; k < 5; k++) begin
      out_drdy = 1'b1;
      out_drd  = 32'hB000_0000 + 32'(k);
      step();
    end
    out_drdy = 1'b0;
    chk("drain_count", 64'(dut.rd_count), 64'(3));

    // Reset with three reads outstanding and a write pending
    set_port(2, 1'b1, 1'b0, 32'h5000_0000, 32'h55);
    reset = 1'b1;
    step();
    chk("mid_out_wr",   64'(out_wr), 64'(0));
    chk("mid_out_addr", 64'(out_addr), 64'(0));
    chk("mid_in_ardy",  64'(in_ardy), 64'(0));
    chk("mid_in_drdy",  64'(in_drdy), 64'(0));
    chk("mid_count",    64'(dut.rd_count), 64'(0));
    chk("mid_rr_ptr",   64'(dut.rr_ptr), 64'(0));
    chk("mid_err",      64'(err), 64'(0));
    exp_rd_port.delete();
    set_port(2, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    step();

    // Stray response after reset
    out_drdy = 1'b1;
    out_drd  = 32'hDEAD;
    step();
    out_drdy = 1'b0;
    chk("unexp_err_set", 64'(err), 64'(1));
    step();
    step();
    chk("unexp_err_hold", 64'(err), 64'(1));
    do_reset();
    chk("unexp_err_clear", 64'(err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
